// File: rtl/iot_sensor_pkg.sv
// iot_sensor_pkg: shared sensor frame types, delimiters and framer state encoding.
//   sensor_type_e    2-bit sensor identifier
//   sensor_packet_t  9-byte frame, byte 0 in the most significant position
//   framer_state_e   framer FSM states
//   packet_byte()    selects byte 0..8 of a frame
package iot_sensor_pkg;

    typedef enum logic [1:0] {
        SENSOR_TEMP,
        SENSOR_HUMID,
        SENSOR_PRESS,
        SENSOR_LIGHT
    } sensor_type_e;

    localparam logic [7:0] PACKET_START_DELIM = 8'h7E;
    localparam logic [7:0] PACKET_END_DELIM   = 8'h7E;
    localparam logic [7:0] PACKET_LENGTH      = 8'h08;
    localparam int         PACKET_BYTES       = 9;

    typedef struct packed {
        logic [7:0]  start_delim;
        logic [7:0]  id_byte;
        logic [7:0]  length;
        logic [15:0] timestamp;
        logic [15:0] data;
        logic [7:0]  checksum;
        logic [7:0]  end_delim;
    } sensor_packet_t;

    typedef enum logic {
        FR_IDLE,
        FR_SEND
    } framer_state_e;

    // Byte 0 is the first field of the packed struct, i.e. the top byte.
    function automatic logic [7:0] packet_byte(input sensor_packet_t p, input logic [3:0] idx);
        logic [PACKET_BYTES-1:0][7:0] b;
        b = p;
        return b[4'(PACKET_BYTES-1) - idx];
    endfunction

endpackage

// File: rtl/packet_checksum.sv
// packet_checksum: combinational checksum over frame bytes 1..6.
//   bytes_i  six payload bytes (order irrelevant)
//   cksum_o  XOR of the bytes by default; with IOT_PKT_CKSUM_SUM_EN defined,
//            the two's complement of their 8-bit sum
module packet_checksum (
    input  logic [5:0][7:0] bytes_i,
    output logic [7:0]      cksum_o
);

    always_comb begin
        cksum_o = '0;
        for (int i = 0; i < 6; i++)
`ifdef IOT_PKT_CKSUM_SUM_EN
            cksum_o = cksum_o + bytes_i[i];
        cksum_o = -cksum_o;
`else
            cksum_o = cksum_o ^ bytes_i[i];
`endif
    end

endmodule

// File: rtl/sensor_packet_framer.sv
// sensor_packet_framer: formats one sensor sample into a 9-byte frame and streams it byte by byte.
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        sample handshake; in_sensor_id, in_timestamp, in_data sample fields
//   out_valid/out_ready      byte handshake; out_byte with out_sof (byte 0) and out_eof (byte 8)
//   busy                     frame in progress
//   frames_sent              completed frames, wraps at 2^CNT_WIDTH
// Checksum mode selected by IOT_PKT_CKSUM_SUM_EN inside packet_checksum.
module sensor_packet_framer
    import iot_sensor_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sensor_id,
    input  logic [15:0]          in_timestamp,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frames_sent
);

    framer_state_e        state_q;
    logic [3:0]           idx_q;
    logic [3:0]           idx_d;
    sensor_packet_t       frame_q;
    logic [7:0]           out_byte_q;
    logic                 sof_q;
    logic                 eof_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [7:0]           cksum;

    assign idx_d = idx_q + 4'd1;

    packet_checksum u_cksum (
        .bytes_i ({frame_q.id_byte, frame_q.length, frame_q.timestamp, frame_q.data}),
        .cksum_o (cksum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FR_IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            out_byte_q <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (state_q == FR_IDLE) begin
            if (in_valid) begin
                frame_q    <= '{start_delim: PACKET_START_DELIM,
                                id_byte:     {in_sensor_id, 6'b0},
                                length:      PACKET_LENGTH,
                                timestamp:   in_timestamp,
                                data:        in_data,
                                checksum:    8'h00,
                                end_delim:   PACKET_END_DELIM};
                idx_q      <= '0;
                out_byte_q <= PACKET_START_DELIM;
                sof_q      <= 1'b1;
                eof_q      <= 1'b0;
                state_q    <= FR_SEND;
            end
        end else begin
            // Checksum is captured while byte 0 is on the bus, long before byte 7 is fetched.
            if (idx_q == 4'd0)
                frame_q.checksum <= cksum;
            if (out_ready) begin
                if (idx_q == 4'd8) begin
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    eof_q   <= 1'b0;
                    state_q <= FR_IDLE;
                end else begin
                    idx_q      <= idx_d;
                    out_byte_q <= packet_byte(frame_q, idx_d);
                    sof_q      <= 1'b0;
                    eof_q      <= (idx_d == 4'd8);
                end
            end
        end
    end

    assign busy        = (state_q == FR_SEND);
    assign out_valid   = busy;
    assign in_ready    = !busy;
    assign out_byte    = out_byte_q;
    assign out_sof     = sof_q;
    assign out_eof     = eof_q;
    assign frames_sent = cnt_q;

endmodule

// File: tb/tb_sensor_packet_framer.sv
// tb_sensor_packet_framer: randomized self-checking bench against a byte-level frame model.
module tb_sensor_packet_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_sensor_id;
    logic [15:0] in_timestamp;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_sof, out_eof, busy;
    logic [7:0]  out_byte;
    logic [15:0] frames_sent;
    logic        in_ready2, out_valid2, out_sof2, out_eof2, busy2;
    logic [7:0]  out_byte2;
    logic [1:0]  frames_sent2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int model_cnt = 0;
    logic [7:0] got [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sensor_packet_framer u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sensor_id(in_sensor_id), .in_timestamp(in_timestamp), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .frames_sent(frames_sent)
    );

    sensor_packet_framer #(.CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_sensor_id(in_sensor_id), .in_timestamp(in_timestamp), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_byte(out_byte2),
        .out_sof(out_sof2), .out_eof(out_eof2), .busy(busy2), .frames_sent(frames_sent2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [1:0] id, input logic [15:0] ts,
                                              input logic [15:0] d, input int k);
        logic [7:0] b [9];
        int acc;
        b[0] = 8'h7E;
        b[1] = {id, 6'b0};
        b[2] = 8'h08;
        b[3] = ts[15:8];
        b[4] = ts[7:0];
        b[5] = d[15:8];
        b[6] = d[7:0];
        b[8] = 8'h7E;
`ifdef IOT_PKT_CKSUM_SUM_EN
        acc = 0;
        for (int i = 1; i <= 6; i++) acc += int'(b[i]);
        b[7] = 8'((256 - acc % 256) % 256);
`else
        acc = 0;
        b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
`endif
        return b[k];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] id, input logic [15:0] ts, input logic [15:0] d,
                              input int stall, input bit hold, output int acc_cyc);
        int t;
        int k;
        bit hs;
        in_sensor_id = id;
        in_timestamp = ts;
        in_data = d;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        check("accept_ready", in_ready, 1);
        acc_cyc = cyc;
        step();
        if (!hold) in_valid = 1'b0;
        k = 0;
        t = 0;
        while (k < 9 && t < 300) begin
            out_ready = ($urandom_range(99) >= stall);
            check("out_valid", out_valid, 1);
            check($sformatf("byte%0d", k), out_byte, model_byte(id, ts, d, k));
            check("sof", out_sof, k == 0);
            check("eof", out_eof, k == 8);
            check("in_ready_send", in_ready, 0);
            check("busy", busy, 1);
            got[k] = out_byte;
            hs = out_ready;
            step();
            if (hs) k++;
            t++;
        end
        check("frame_done", k, 9);
        model_cnt++;
        check("frames_sent", frames_sent, model_cnt % 65536);
        check("frames_sent_w2", frames_sent2, model_cnt % 4);
        check("out_valid_end", out_valid, 0);
        check("in_ready_end", in_ready, 1);
        check("busy_end", busy, 0);
    endtask

    initial begin
        int a;
        int prev;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_sensor_id = '0;
        in_timestamp = '0;
        in_data = '0;
        repeat (2) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eof", out_eof, 0);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_frames_w2", frames_sent2, 0);
        rst = 1'b0;
        step();

        send_frame(2'd1, 16'h1234, 16'hABCD, 0, 1'b0, a);
`ifdef IOT_PKT_CKSUM_SUM_EN
        check("directed_cksum", got[7], 8'hFA);
`else
        check("directed_cksum", got[7], 8'h08);
`endif
        check("directed_b1", got[1], 8'h40);

        for (int i = 0; i < 6; i++) begin
            if (i == 2) send_frame(2'($urandom), 16'h7E7E, 16'h7E7E, 60, 1'b0, a);
            else send_frame(2'($urandom), 16'($urandom), 16'($urandom), 60, 1'b0, a);
            repeat ($urandom_range(3)) begin
                step();
                check("idle_valid", out_valid, 0);
            end
        end

        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send_frame(2'($urandom), 16'($urandom), 16'($urandom), 0, 1'b1, a);
            if (i > 0) check("frame_period", a - prev, 10);
            prev = a;
        end
        in_valid = 1'b0;
        step();

        in_sensor_id = 2'd3;
        in_timestamp = 16'hBEEF;
        in_data = 16'h0102;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("pre_rst_byte4", out_byte, model_byte(2'd3, 16'hBEEF, 16'h0102, 4));
        rst = 1'b1;
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frames", frames_sent, 0);
        check("mid_rst_frames_w2", frames_sent2, 0);
        check("mid_rst_in_ready", in_ready, 1);
        rst = 1'b0;
        model_cnt = 0;
        repeat (3) begin
            step();
            check("post_rst_idle", out_valid, 0);
        end
        send_frame(2'($urandom), 16'($urandom), 16'($urandom), 30, 1'b0, a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_packet_framer.md
# sensor_packet_framer

Converts one accepted sensor sample (sensor ID, 16-bit timestamp, 16-bit data) into the fixed 9-byte `sensor_packet_t` frame and streams it out one byte per handshake. It sits downstream of the priority arbiter/FIFO and upstream of the UART transmitter. It is the only block that formats frames.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the frames-sent counter.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample available.
- `in_ready`  out  1  framer can accept a sample.
- `in_sensor_id`  in  2  `sensor_type_e` of the sample.
- `in_timestamp`  in  16  sample timestamp.
- `in_data`  in  16  sample data.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  downstream (UART TX) accepts `out_byte`.
- `out_byte`  out  8  current frame byte.
- `out_sof`  out  1  high with byte 0 of a frame.
- `out_eof`  out  1  high with byte 8 of a frame.
- `busy`  out  1  a frame is in progress.
- `frames_sent`  out  `CNT_WIDTH`  count of completed frames; wraps modulo 2^`CNT_WIDTH`.

## Operation
- Frame byte order, index 0..8:
  - 0: `PACKET_START_DELIM` (0x7E).
  - 1: {sensor_id, 6'b0}.
  - 2: `PACKET_LENGTH` (0x08).
  - 3: ts[15:8]; 4: ts[7:0].
  - 5: data[15:8]; 6: data[7:0].
  - 7: checksum.
  - 8: `PACKET_END_DELIM` (0x7E).
- Default checksum: XOR of bytes 1–6.
- The checksum is computed once, from the latched fields, in the cycle after accept.
- FSM has two states:
  - IDLE: `in_ready`=1, `out_valid`=0. On `in_valid&&in_ready`, latch all input fields, clear the byte index to 0, go to SEND.
  - SEND: `out_valid`=1, `out_byte`=byte[index]. On `out_valid&&out_ready`:
    - index<8: index increments.
    - index==8: `frames_sent` increments and the FSM returns to IDLE.
- The byte index is a 4-bit counter that never exceeds 8.
- No delimiter byte-stuffing is performed. Payload bytes equal to 0x7E are sent unchanged.
- Reset at any time, including mid-frame: the frame is abandoned and no remainder is sent later.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_byte`=0x00, `out_sof`=0, `out_eof`=0, `busy`=0, `frames_sent`=0. The FSM resets to IDLE.
- Accept at cycle N gives `out_valid`=1 with byte 0 at cycle N+1. Latency is 1 cycle.
- `out_byte`, `out_sof` and `out_eof` are registered and held stable while `out_valid && !out_ready`.
- `out_valid` never drops mid-frame.
- With `out_ready` tied high, a frame takes 9 cycles.
- `in_ready` reasserts the cycle after the byte-8 handshake, so the minimum period is 10 cycles per frame.
- `in_ready` is 0 in SEND. `in_valid` during SEND is ignored and no sample is lost from the upstream's side, because it must hold until ready.
- `busy` = (state==SEND).
- `frames_sent` updates the cycle after the byte-8 handshake and wraps from all-ones to 0.

## Configuration
- Macro: `IOT_PKT_CKSUM_SUM_EN`.
- Defined: checksum = two's complement of the 8-bit modular sum of bytes 1–6, so that bytes 1–7 sum to 0x00 mod 256.
- Undefined: checksum = XOR of bytes 1–6.
- Frame length, order and timing are identical in both modes.

## Structure
- Shared package `iot_sensor_pkg` provides `sensor_packet_t`, `sensor_type_e`, `PACKET_START_DELIM`, `PACKET_END_DELIM` and `PACKET_LENGTH`.
- Add to the package:
  - `PACKET_BYTES` = 9.
  - A `framer_state_e` enum {FR_IDLE, FR_SEND}.
- Sub-module `packet_checksum`: a combinational checksum over six bytes. The macro is applied there only.
- Frame assembly is a packed `sensor_packet_t` register, indexed by byte.

## Test plan
- Macro undefined; id=1, ts=0x1234, data=0xABCD; `out_ready`=1 → bytes 7E,40,08,12,34,AB,CD,08,7E on 9 consecutive cycles; `out_sof` on byte 0, `out_eof` on byte 8; `frames_sent`=1.
- Same stimulus with `IOT_PKT_CKSUM_SUM_EN` defined → byte 7 = 0xFA, all other bytes unchanged.
- Random `out_ready` stalls (≥50% low) → byte sequence identical; `out_byte` stable during every stall; `in_ready`=0 throughout the frame.
- `in_valid` held high continuously with `out_ready`=1 → a new frame starts every 10 cycles; `frames_sent` increments once per frame.
- Assert `rst` during byte 4 → next cycle `out_valid`=0, `busy`=0, `frames_sent`=0; the next accepted sample produces a clean frame starting with 7E.
- `CNT_WIDTH`=2, send 5 frames → `frames_sent` reads 1,2,3,0,1.
